ram_seq_ctrl: RTL and testbench
===============================

RAM_SEQ_CTRL -- requirements
Module: ram_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: RAM data width.
REQ-002 Parameter ADDR_W, default 8: RAM address width; DEPTH = 2^ADDR_W.
REQ-003 Parameter TICK_MAX, default 4_999_999: tick counter terminal value; one tick every TICK_MAX+1 cycles.
REQ-004 Parameter JUMP_ADDR, default 100: address loaded on entry to RUN_J.
REQ-005 Parameter WR_STEP, default 2: data increment per fill write.
REQ-006 Parameter RD_LAT, default 2: RAM read latency in cycles, range 1..4.
REQ-007 sys_clk  input  1  clock, all logic on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 key_flag  input  1  debounced key press, one-cycle pulse.
REQ-010 dir  input  1  stepping direction: 0 increment, 1 decrement; sampled on each tick.
REQ-011 wren  output  1  RAM write enable.
REQ-012 rden  output  1  RAM read enable, always equal to NOT wren.
REQ-013 addr  output  ADDR_W  RAM read/write address, registered.
REQ-014 data_in  output  DATA_W  RAM write data, registered.
REQ-015 rd_valid  output  1  one-cycle pulse: RAM q is valid for rd_addr.
REQ-016 rd_addr  output  ADDR_W  address whose read data is presented with rd_valid.
REQ-017 mode  output  2  current state: 0 RUN, 1 HOLD, 2 RUN_J, 3 FILL.

Function
REQ-018 Tick counter SHALL count 0..TICK_MAX and wrap to 0, asserting an internal one-cycle tick on the wrap cycle.
REQ-019 FSM SHALL advance on key_flag: RUN->HOLD, HOLD->RUN_J, RUN_J->FILL; key_flag in FILL SHALL be ignored.
REQ-020 In RUN and RUN_J, on tick, addr SHALL step by +1 (dir=0) or -1 (dir=1), modulo DEPTH (DEPTH-1 -> 0, 0 -> DEPTH-1).
REQ-021 In HOLD addr SHALL not change.
REQ-022 On HOLD->RUN_J, addr SHALL load JUMP_ADDR (truncated to ADDR_W) in the same edge.
REQ-023 On RUN_J->FILL, addr SHALL load 0, data_in SHALL load fill seed S, wren SHALL assert the next cycle.
REQ-024 In FILL, one write per cycle: cycle k drives addr=k, data_in=(S + k*WR_STEP) mod 2^DATA_W, k = 0..DEPTH-1.
REQ-025 After write k=DEPTH-1, FSM SHALL enter RUN with addr=0, wren=0, tick counter cleared to 0; FILL lasts exactly DEPTH cycles.
REQ-026 Fill seed S SHALL reset to 0 and increment by 1 (mod 2^DATA_W) at the end of each FILL pass.
REQ-027 key_flag coincident with tick SHALL take priority: state transition applies, no address step that cycle.
REQ-028 rd_valid SHALL pulse RD_LAT cycles after each cycle in which addr changes while rden=1 (including reset exit at addr 0 and FILL exit), with rd_addr equal to that addr.
REQ-029 Read-pending pipeline SHALL be flushed when wren asserts; no rd_valid during FILL or for accesses issued before FILL.
REQ-030 data_in SHALL hold its last value outside FILL.

Reset
REQ-031 On rst_n low, immediately: mode=RUN, addr=0, data_in=0, wren=0, rden=1, rd_valid=0, rd_addr=0, tick counter=0, S=0, read pipeline cleared.
REQ-032 Reset asserted mid-FILL SHALL abort the fill; no further writes after release, S stays 0.
REQ-033 First rd_valid after reset release SHALL occur RD_LAT cycles after the first active edge, rd_addr=0.

Verification (TICK_MAX=9, ADDR_W=4, defaults otherwise)
REQ-034 Release reset, dir=0, run 35 cycles -> addr steps 0,1,2,3 at cycles 10,20,30; rd_valid pulses RD_LAT after each step with matching rd_addr.
REQ-035 dir=1 from addr 0 on tick -> addr=15; dir=0 at addr 15 on tick -> addr=0.
REQ-036 key_flag in RUN then HOLD -> addr frozen through 3 ticks in HOLD, then addr=JUMP_ADDR mod 16 (4), mode=2.
REQ-037 key_flag in RUN_J -> 16 consecutive cycles wren=1, addr 0..15, data_in 0,2,..,30; then mode=0, addr=0, wren=0; second fill writes 1,3,..,31.
REQ-038 key_flag during FILL and key_flag coincident with tick in RUN -> FILL unaffected; tick case enters HOLD with no step.
REQ-039 rst_n low at fill write k=7 -> outputs at reset values instantly, no writes after release, next fill data starts at 0.

Source files
------------

// File: rtl/ram_seq_ctrl.sv
// RAM address/data sequencer: ticked address stepping, hold, jump and full-RAM fill
// passes, plus a read-valid pipeline that tracks RAM read latency.
module ram_seq_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int TICK_MAX  = 4_999_999,
    parameter int JUMP_ADDR = 100,
    parameter int WR_STEP   = 2,
    parameter int RD_LAT    = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              key_flag,
    input  logic              dir,
    output logic              wren,
    output logic              rden,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        mode
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        RUN_J = 2'd2,
        FILL  = 2'd3
    } state_t;

    localparam int CNT_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic [DATA_W-1:0] seed;
    logic              boot;
    logic [ADDR_W-1:0] addr_step;
    logic [ADDR_W-1:0] addr_nx;
    logic              wren_nx;
    logic              fill_last;
    logic              rd_issue;
    logic [RD_LAT-1:0] pipe_v;
    logic [ADDR_W-1:0] pipe_a [RD_LAT];

    assign tick      = (tick_cnt == CNT_W'(TICK_MAX));
    assign fill_last = (state == FILL) && (addr == '1);
    assign addr_step = dir ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    assign rden      = ~wren;
    assign mode      = state;

    // Next address / write enable, shared by the FSM and the read-issue detector.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        addr_nx = addr;
        wren_nx = wren;
        unique case (state)
            RUN:   if (!key_flag && tick) addr_nx = addr_step;
            HOLD:  if (key_flag) addr_nx = ADDR_W'(JUMP_ADDR);
            RUN_J: begin
                if (key_flag) begin
                    addr_nx = '0;
                    wren_nx = 1'b1;
                end else if (tick) begin
                    addr_nx = addr_step;
                end
            end
            FILL: begin
                if (fill_last) begin
                    addr_nx = '0;
                    wren_nx = 1'b0;
                end else begin
                    addr_nx = addr + ADDR_W'(1);
                end
            end
            default: ;
        endcase
        rd_issue = !wren_nx && (boot || (addr_nx != addr));
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (fill_last || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state   <= RUN;
            addr    <= '0;
            wren    <= 1'b0;
            data_in <= '0;
            seed    <= '0;
            boot    <= 1'b1;
        end else begin
            boot <= 1'b0;
            addr <= addr_nx;
            wren <= wren_nx;
            unique case (state)
                RUN:   if (key_flag) state <= HOLD;
                HOLD:  if (key_flag) state <= RUN_J;
                RUN_J: begin
                    if (key_flag) begin
                        state   <= FILL;
                        data_in <= seed;
                    end
                end
                FILL: begin
                    if (fill_last) begin
                        state <= RUN;
                        seed  <= seed + DATA_W'(1);
                    end else begin
                        data_in <= data_in + DATA_W'(WR_STEP);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Read-valid pipeline; a write pass discards anything still in flight.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v   <= '0;
            rd_valid <= 1'b0;
            rd_addr  <= '0;
        end else if (wren_nx) begin
            pipe_v   <= '0;
            rd_valid <= 1'b0;
        end else begin
            pipe_v[0] <= rd_issue;
            for (int i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
            rd_valid <= pipe_v[RD_LAT-1];
            if (pipe_v[RD_LAT-1]) rd_addr <= pipe_a[RD_LAT-1];
        end
    end

    // NOTE: the address pipeline has no reset; each entry is only consumed when its
    // matching pipe_v bit is set, and pipe_v is reset.
    always_ff @(posedge sys_clk) begin
        pipe_a[0] <= addr_nx;
        for (int i = 1; i < RD_LAT; i++) pipe_a[i] <= pipe_a[i-1];
    end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl with TICK_MAX=9, ADDR_W=4: stepping, wrap, hold/jump,
// fill passes, read-valid timing and reset during a fill.
module tb_ram_seq_ctrl;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       key_flag;
    logic       dir;
    logic       wren;
    logic       rden;
    logic [3:0] addr;
    logic [7:0] data_in;
    logic       rd_valid;
    logic [3:0] rd_addr;
    logic [1:0] mode;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    ram_seq_ctrl #(
        .DATA_W(8), .ADDR_W(4), .TICK_MAX(9), .JUMP_ADDR(100), .WR_STEP(2), .RD_LAT(2)
    ) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .key_flag(key_flag),
        .dir     (dir),
        .wren    (wren),
        .rden    (rden),
        .addr    (addr),
        .data_in (data_in),
        .rd_valid(rd_valid),
        .rd_addr (rd_addr),
        .mode    (mode)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, want %0d", tag, edge_n, obs, exp);
        end
    endtask

    // Advance to just after active edge n (counted from reset release).
    task automatic run_to(input int n);
        while (edge_n < n) begin
            @(posedge sys_clk);
            #1;
            edge_n++;
        end
    endtask

    // key_flag high during the cycle that ends with edge n.
    task automatic key_at(input int n);
        run_to(n - 1);
        key_flag = 1'b1;
        run_to(n);
        key_flag = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_wren"}, wren, 0);
        check({tag, "_rden"}, rden, 1);
        check({tag, "_data"}, data_in, 0);
        check({tag, "_rdv"},  rd_valid, 0);
        check({tag, "_rda"},  rd_addr, 0);
    endtask

    initial begin
        logic exp_v;
        rst_n    = 1'b0;
        key_flag = 1'b0;
        dir      = 1'b0;
        #3;
        check_reset_vals("rst");
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;

        // Ticks at edges 10, 20, 30; reads valid two edges after each address change.
        for (int e = 1; e <= 35; e++) begin
            run_to(e);
            check("run_addr", addr, e / 10);
            exp_v = (e == 3) || (e == 12) || (e == 22) || (e == 32);
            check("run_rdv", rd_valid, exp_v);
            if (exp_v) check("run_rda", rd_addr, (e == 3) ? 0 : (e - 2) / 10);
        end

        // Decrement through zero, then increment back across the top.
        dir = 1'b1;
        run_to(60);
        check("dec_addr0", addr, 0);
        run_to(70);
        check("dec_wrap", addr, 15);
        dir = 1'b0;
        run_to(72);
        check("wrap_rdv", rd_valid, 1);
        check("wrap_rda", rd_addr, 15);
        run_to(80);
        check("inc_wrap", addr, 0);

        // Key coincident with tick at edge 90: HOLD entered, no step.
        key_at(90);
        check("hold_mode", mode, 1);
        check("hold_addr", addr, 0);
        run_to(92);
        check("hold_rdv", rd_valid, 0);
        run_to(121);
        check("hold_frozen", addr, 0);
        key_at(125);
        check("runj_mode", mode, 2);
        check("runj_addr", addr, 4);
        run_to(127);
        check("runj_rdv", rd_valid, 1);
        check("runj_rda", rd_addr, 4);
        run_to(130);
        check("runj_step", addr, 5);

        // Enter FILL one edge after a step: the pending read must be dropped.
        key_at(131);
        for (int k = 0; k < 16; k++) begin
            run_to(131 + k);
            check("fill1_mode", mode, 3);
            check("fill1_wren", wren, 1);
            check("fill1_rden", rden, 0);
            check("fill1_addr", addr, k);
            check("fill1_data", data_in, 2 * k);
            check("fill1_rdv", rd_valid, 0);
            if (k == 3) key_flag = 1'b1;
            if (k == 4) key_flag = 1'b0;
        end
        run_to(147);
        check("fill1_exit_mode", mode, 0);
        check("fill1_exit_addr", addr, 0);
        check("fill1_exit_wren", wren, 0);
        check("fill1_hold_data", data_in, 30);
        run_to(149);
        check("fill1_exit_rdv", rd_valid, 1);
        check("fill1_exit_rda", rd_addr, 0);
        run_to(156);
        check("tick_clr_addr0", addr, 0);
        run_to(157);
        check("tick_clr_addr1", addr, 1);

        // Second pass uses seed 1.
        key_at(160);
        key_at(162);
        key_at(164);
        for (int k = 0; k < 16; k++) begin
            run_to(164 + k);
            check("fill2_addr", addr, k);
            check("fill2_data", data_in, 1 + 2 * k);
            check("fill2_wren", wren, 1);
        end
        run_to(180);
        check("fill2_exit_mode", mode, 0);
        check("fill2_hold_data", data_in, 31);

        // Third pass (seed 2) aborted by reset at write k=7.
        key_at(183);
        key_at(185);
        key_at(187);
        run_to(194);
        check("fill3_addr", addr, 7);
        check("fill3_data", data_in, 16);
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(posedge sys_clk);
        #1;
        rst_n  = 1'b1;
        edge_n = 0;
        for (int e = 1; e <= 22; e++) begin
            run_to(e);
            check("post_rst_wren", wren, 0);
        end
        key_at(23);
        key_at(25);
        key_at(27);
        check("seed_rst_mode", mode, 3);
        check("seed_rst_data0", data_in, 0);
        run_to(28);
        check("seed_rst_addr1", addr, 1);
        check("seed_rst_data1", data_in, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
